// File: rtl/datapath_pkg.sv
// Shared encodings for the parametrised datapath: ALU/shifter opcodes,
// PSW flag layout and the multiplier sequencer states.
package datapath_pkg;

  typedef enum logic [2:0] {
    ALU_ADD    = 3'd0,
    ALU_ADC    = 3'd1,
    ALU_SUB    = 3'd2,
    ALU_SBC    = 3'd3,
    ALU_AND    = 3'd4,
    ALU_OR     = 3'd5,
    ALU_XOR    = 3'd6,
    ALU_PASS_A = 3'd7
  } alu_op_e;

  typedef enum logic [2:0] {
    SHF_ASL = 3'd0,
    SHF_ASR = 3'd1,
    SHF_LSL = 3'd2,
    SHF_LSR = 3'd3,
    SHF_ROL = 3'd4,
    SHF_ROR = 3'd5,
    SHF_RLC = 3'd6,
    SHF_RRC = 3'd7
  } shf_op_e;

  localparam int unsigned FLAG_W = 4;
  localparam int unsigned FLG_N  = 3;
  localparam int unsigned FLG_Z  = 2;
  localparam int unsigned FLG_V  = 1;
  localparam int unsigned FLG_C  = 0;

  // Field order matches the FLG_* bit positions.
  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } flags_t;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/seq_multiplier.sv
// Unsigned shift-add multiplier, one partial product per cycle, with a
// start/busy/done handshake. The product register holds until the next start.
module seq_multiplier
  import datapath_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  mul_state_e       state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   partial;

  // Upper half plus the multiplicand when the current multiplier bit is set.
  assign partial = {1'b0, product[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);

  // After WIDTH steps one extra RUN cycle closes out, so done lands WIDTH+1 edges after start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= MUL_IDLE;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        MUL_IDLE: begin
          if (start) begin
            mcand   <= a;
            mplier  <= b;
            product <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= MUL_RUN;
          end
        end
        MUL_RUN: begin
          if (cnt == CNT_W'(WIDTH)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= MUL_DONE;
          end else begin
            product <= {partial, product[WIDTH-1:1]};
            mplier  <= mplier >> 1;
            cnt     <= cnt + CNT_W'(1);
          end
        end
        MUL_DONE: begin
          done  <= 1'b0;
          state <= MUL_IDLE;
        end
        default: state <= MUL_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/datapath_core.sv
// Parametrised register/ALU/shifter/multiplier datapath on OR-combined A/B/S
// buses, driven by the microcode controller strobes.
module datapath_core
  import datapath_pkg::*;
#(
  parameter int unsigned      WIDTH   = 16,
  parameter int unsigned      NREG    = 8,
  parameter int unsigned      PSW_IDX = 5,
  parameter logic [WIDTH-1:0] KONST0  = WIDTH'(16'h0080),
  parameter logic [WIDTH-1:0] KONST1  = WIDTH'(16'h00C0)
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [WIDTH-1:0] M_bus_in,
  output logic [WIDTH-1:0] M_bus_out,
  output logic [WIDTH-1:0] MAR_out,
  input  logic [NREG-1:0]  RA,
  input  logic [NREG-1:0]  SR,
  input  logic             MDA,
  input  logic             MMD,
  input  logic             SMD,
  input  logic             MDM,
  input  logic             SMA,
  input  logic             SB0,
  input  logic             B0B,
  input  logic [2:0]       alu_op,
  input  logic [2:0]       shf_op,
  input  logic             ALS,
  input  logic             SHS,
  input  logic             SK0,
  input  logic             SK1,
  input  logic             mul_start,
  input  logic             MLH,
  input  logic             MLL,
  output logic             mul_busy,
  output logic             mul_done,
  input  logic             FLG_ALU,
  input  logic             FLG_SFT,
  input  logic             FLG_MUL,
  output logic [3:0]       psw
);

  localparam int unsigned EXT_W = WIDTH + 1;
  localparam int unsigned MSB   = WIDTH - 1;

  logic [WIDTH-1:0]   gpr [NREG];
  logic [WIDTH-1:0]   b0;
  logic [WIDTH-1:0]   mdr;
  logic [WIDTH-1:0]   mar;
  flags_t             psw_q;

  logic [WIDTH-1:0]   a_bus;
  logic [WIDTH-1:0]   b_bus;
  logic [WIDTH-1:0]   s_bus;
  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH-1:0]   shf_res;
  logic [2*WIDTH-1:0] product;

  logic [EXT_W-1:0]   a_ext;
  logic [EXT_W-1:0]   b_ext;
  logic [EXT_W-1:0]   cin_ext;
  logic [EXT_W-1:0]   alu_ext;
  logic               alu_arith;
  logic               alu_sub;
  logic               shf_c;
  flags_t             alu_flg;
  flags_t             shf_flg;
  flags_t             mul_flg;

  // A bus: selected GPRs (PSW slot reads the zero-extended flags) and MDR.
  always_comb begin
    a_bus = '0;
    for (int i = 0; i < NREG; i++) begin
      if (RA[i]) begin
        a_bus = a_bus | ((i == PSW_IDX) ? WIDTH'(psw_q) : gpr[i]);
      end
    end
    if (MDA) a_bus = a_bus | mdr;
  end

  assign b_bus = {WIDTH{B0B}} & b0;

  assign s_bus = ({WIDTH{ALS}} & alu_res)
               | ({WIDTH{SHS}} & shf_res)
               | ({WIDTH{SK0}} & KONST0)
               | ({WIDTH{SK1}} & KONST1)
               | ({WIDTH{MLH}} & product[2*WIDTH-1:WIDTH])
               | ({WIDTH{MLL}} & product[WIDTH-1:0]);

  assign a_ext   = {1'b0, a_bus};
  assign b_ext   = {1'b0, b_bus};
  assign cin_ext = EXT_W'(psw_q[FLG_C]);

  // ALU in WIDTH+1 bits so bit WIDTH is carry (add) or borrow (subtract).
  always_comb begin
    alu_ext   = a_ext;
    alu_arith = 1'b0;
    alu_sub   = 1'b0;
    case (alu_op_e'(alu_op))
      ALU_ADD: begin alu_ext = a_ext + b_ext;           alu_arith = 1'b1; end
      ALU_ADC: begin alu_ext = a_ext + b_ext + cin_ext; alu_arith = 1'b1; end
      ALU_SUB: begin alu_ext = a_ext - b_ext;           alu_arith = 1'b1; alu_sub = 1'b1; end
      ALU_SBC: begin alu_ext = a_ext - b_ext - cin_ext; alu_arith = 1'b1; alu_sub = 1'b1; end
      ALU_AND: alu_ext = a_ext & b_ext;
      ALU_OR:  alu_ext = a_ext | b_ext;
      ALU_XOR: alu_ext = a_ext ^ b_ext;
      default: alu_ext = a_ext;
    endcase
  end

  assign alu_res = alu_ext[WIDTH-1:0];

  always_comb begin
    alu_flg   = '0;
    alu_flg.n = alu_res[MSB];
    alu_flg.z = (alu_res == '0);
    alu_flg.c = alu_arith & alu_ext[WIDTH];
    alu_flg.v = alu_arith & (alu_res[MSB] != a_bus[MSB])
              & (alu_sub ? (a_bus[MSB] != b_bus[MSB]) : (a_bus[MSB] == b_bus[MSB]));
  end

  // Shifter operates on the A bus; shf_c is the bit shifted out.
  always_comb begin
    shf_res = a_bus;
    shf_c   = 1'b0;
    case (shf_op_e'(shf_op))
      SHF_ASL, SHF_LSL: begin shf_res = {a_bus[MSB-1:0], 1'b0};        shf_c = a_bus[MSB]; end
      SHF_ASR:          begin shf_res = {a_bus[MSB], a_bus[MSB:1]};    shf_c = a_bus[0];   end
      SHF_LSR:          begin shf_res = {1'b0, a_bus[MSB:1]};          shf_c = a_bus[0];   end
      SHF_ROL:          begin shf_res = {a_bus[MSB-1:0], a_bus[MSB]};  shf_c = a_bus[MSB]; end
      SHF_ROR:          begin shf_res = {a_bus[0], a_bus[MSB:1]};      shf_c = a_bus[0];   end
      SHF_RLC:          begin shf_res = {a_bus[MSB-1:0], psw_q.c};     shf_c = a_bus[MSB]; end
      SHF_RRC:          begin shf_res = {psw_q.c, a_bus[MSB:1]};       shf_c = a_bus[0];   end
      default:          begin shf_res = a_bus;                         shf_c = 1'b0;       end
    endcase
  end

  always_comb begin
    shf_flg   = '0;
    shf_flg.n = shf_res[MSB];
    shf_flg.z = (shf_res == '0);
    shf_flg.c = shf_c;
    shf_flg.v = (shf_op_e'(shf_op) == SHF_ASL) ? (shf_res[MSB] ^ shf_c) : 1'b0;
  end

  always_comb begin
    mul_flg   = '0;
    mul_flg.n = product[2*WIDTH-1];
    mul_flg.z = (product == '0);
    mul_flg.c = |product[2*WIDTH-1:WIDTH];
  end

  // Register file, B0, MDR, MAR and PSW; PSW-slot writes land in the flags.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      for (int i = 0; i < NREG; i++) gpr[i] <= '0;
      b0    <= '0;
      mdr   <= '0;
      mar   <= '0;
      psw_q <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (SR[i] && (i != PSW_IDX)) gpr[i] <= s_bus;
      end
      if (SB0) b0 <= s_bus;
      if (MMD)      mdr <= M_bus_in;
      else if (SMD) mdr <= s_bus;
      if (SMA) mar <= s_bus;
      if (SR[PSW_IDX])  psw_q <= flags_t'(s_bus[FLAG_W-1:0]);
      else if (FLG_MUL) psw_q <= mul_flg;
      else if (FLG_ALU) psw_q <= alu_flg;
      else if (FLG_SFT) psw_q <= shf_flg;
    end
  end

  seq_multiplier #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (CLK),
    .rst     (CLR),
    .start   (mul_start),
    .a       (a_bus),
    .b       (b_bus),
    .product (product),
    .busy    (mul_busy),
    .done    (mul_done)
  );

  assign M_bus_out = {WIDTH{MDM}} & mdr;
  assign MAR_out   = mar;
  assign psw       = psw_q;

endmodule

// File: tb/tb_datapath_core.sv
// Scoreboard bench for datapath_core: expectations are queued as stimulus is
// driven and compared once the clock edge has produced the DUT outputs.
module tb_datapath_core;
  import datapath_pkg::*;

  localparam int unsigned WIDTH   = 16;
  localparam int unsigned NREG    = 8;
  localparam int unsigned PSW_IDX = 5;

  logic             CLK = 1'b0;
  logic             CLR;
  logic [WIDTH-1:0] M_bus_in, M_bus_out, MAR_out;
  logic [NREG-1:0]  RA, SR;
  logic             MDA, MMD, SMD, MDM, SMA, SB0, B0B;
  logic [2:0]       alu_op, shf_op;
  logic             ALS, SHS, SK0, SK1, mul_start, MLH, MLL;
  logic             mul_busy, mul_done;
  logic             FLG_ALU, FLG_SFT, FLG_MUL;
  logic [3:0]       psw;

  datapath_core #(.WIDTH(WIDTH), .NREG(NREG), .PSW_IDX(PSW_IDX)) dut (
    .CLK(CLK), .CLR(CLR), .M_bus_in(M_bus_in), .M_bus_out(M_bus_out), .MAR_out(MAR_out),
    .RA(RA), .SR(SR), .MDA(MDA), .MMD(MMD), .SMD(SMD), .MDM(MDM), .SMA(SMA),
    .SB0(SB0), .B0B(B0B), .alu_op(alu_op), .shf_op(shf_op), .ALS(ALS), .SHS(SHS),
    .SK0(SK0), .SK1(SK1), .mul_start(mul_start), .MLH(MLH), .MLL(MLL),
    .mul_busy(mul_busy), .mul_done(mul_done), .FLG_ALU(FLG_ALU), .FLG_SFT(FLG_SFT),
    .FLG_MUL(FLG_MUL), .psw(psw)
  );

  always #5 CLK = ~CLK;

  typedef enum int {OBS_MAR, OBS_PSW, OBS_MBO, OBS_BUSY, OBS_DONE} obs_e;
  typedef struct {
    obs_e        sel;
    logic [31:0] val;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input obs_e sel, input logic [31:0] val);
    exp_t e;
    e.sel = sel;
    e.val = val;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  function automatic logic [31:0] observe(input obs_e sel);
    case (sel)
      OBS_MAR:  return 32'(MAR_out);
      OBS_PSW:  return 32'(psw);
      OBS_MBO:  return 32'(M_bus_out);
      OBS_BUSY: return 32'(mul_busy);
      default:  return 32'(mul_done);
    endcase
  endfunction

  task automatic drain();
    exp_t  e;
    string t;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_eq(t, observe(e.sel), e.val);
    end
  endtask

  task automatic idle();
    M_bus_in = '0; RA = '0; SR = '0;
    {MDA, MMD, SMD, MDM, SMA, SB0, B0B} = '0;
    alu_op = '0; shf_op = '0;
    {ALS, SHS, SK0, SK1, mul_start, MLH, MLL, FLG_ALU, FLG_SFT, FLG_MUL} = '0;
  endtask

  // One clock: outputs sampled 1 time unit after the edge, then inputs cleared.
  task automatic tick();
    @(posedge CLK);
    #1;
    drain();
    idle();
  endtask

  // Memory -> MDR -> A -> PASS_A -> S -> register (PSW slot loads the flags).
  task automatic load_reg(input int idx, input logic [WIDTH-1:0] v);
    M_bus_in = v; MMD = 1'b1;
    tick();
    MDA = 1'b1; alu_op = ALU_PASS_A; ALS = 1'b1; SR[idx] = 1'b1;
    tick();
  endtask

  task automatic load_b0(input logic [WIDTH-1:0] v);
    M_bus_in = v; MMD = 1'b1;
    tick();
    MDA = 1'b1; alu_op = ALU_PASS_A; ALS = 1'b1; SB0 = 1'b1;
    tick();
  endtask

  task automatic alu_check(input string tag, input int ra, input logic [2:0] op,
                           input logic [WIDTH-1:0] exp_v, input logic [3:0] exp_f);
    RA[ra] = 1'b1; B0B = 1'b1; alu_op = op; ALS = 1'b1; FLG_ALU = 1'b1; SMA = 1'b1;
    expect_out({tag, "_res"}, OBS_MAR, 32'(exp_v));
    expect_out({tag, "_psw"}, OBS_PSW, 32'(exp_f));
    tick();
  endtask

  task automatic shf_check(input string tag, input int ra, input logic [2:0] op,
                           input logic [WIDTH-1:0] exp_v, input logic [3:0] exp_f);
    RA[ra] = 1'b1; shf_op = op; SHS = 1'b1; FLG_SFT = 1'b1; SMA = 1'b1;
    expect_out({tag, "_res"}, OBS_MAR, 32'(exp_v));
    expect_out({tag, "_psw"}, OBS_PSW, 32'(exp_f));
    tick();
  endtask

  // Start a multiply of R[ra] x B0, optionally poke mul_start at cycle poke_at, check latency and halves.
  task automatic mul_run(input string tag, input int ra, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input int poke_at);
    logic [31:0] prod_m;
    int          lat;
    prod_m = 32'(a) * 32'(b);
    load_reg(ra, a);
    load_b0(b);
    RA[ra] = 1'b1; B0B = 1'b1; mul_start = 1'b1;
    expect_out({tag, "_busy"}, OBS_BUSY, 32'd1);
    tick();
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      if (n == poke_at) mul_start = 1'b1;
      @(posedge CLK);
      #1;
      mul_start = 1'b0;
      if (mul_done) begin
        lat = n;
        break;
      end
    end
    check_eq({tag, "_latency"}, 32'(lat), 32'(WIDTH + 1));
    expect_out({tag, "_busy_at_done"}, OBS_BUSY, 32'd0);
    drain();
    MLH = 1'b1; SMA = 1'b1;
    expect_out({tag, "_mlh"}, OBS_MAR, 32'(prod_m[31:16]));
    tick();
    MLL = 1'b1; SMA = 1'b1;
    expect_out({tag, "_mll"}, OBS_MAR, 32'(prod_m[15:0]));
    expect_out({tag, "_done_pulse"}, OBS_DONE, 32'd0);
    tick();
    FLG_MUL = 1'b1;
    expect_out({tag, "_psw"}, OBS_PSW,
               32'({prod_m[31], prod_m == 32'd0, 1'b0, prod_m[31:16] != 16'd0}));
    tick();
  endtask

  initial begin
    idle();
    CLR = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    MDM = 1'b1;
    #1;
    expect_out("rst_busy", OBS_BUSY, 32'd0);
    expect_out("rst_done", OBS_DONE, 32'd0);
    expect_out("rst_psw",  OBS_PSW,  32'd0);
    expect_out("rst_mar",  OBS_MAR,  32'd0);
    expect_out("rst_mdr",  OBS_MBO,  32'd0);
    drain();
    idle();
    CLR = 1'b0;

    // ALU: signed overflow into the sign bit, borrow chain through SBC.
    load_reg(1, 16'h7FFF);
    load_b0(16'h0001);
    alu_check("add_ovf", 1, ALU_ADD, 16'h8000, 4'b1010);
    load_reg(2, 16'h0000);
    alu_check("sub_borrow", 2, ALU_SUB, 16'hFFFF, 4'b1001);
    load_reg(3, 16'h0005);
    load_b0(16'h0002);
    alu_check("sbc", 3, ALU_SBC, 16'h0002, 4'b0000);
    alu_check("xor", 3, ALU_XOR, 16'h0007, 4'b0000);

    // Shifter: rotate through carry, ASL overflow, zero result.
    load_reg(4, 16'h0001);
    load_reg(PSW_IDX, 16'h0001);
    shf_check("rrc", 4, SHF_RRC, 16'h8000, 4'b1001);
    load_reg(6, 16'h4000);
    shf_check("asl", 6, SHF_ASL, 16'h8000, 4'b1010);
    shf_check("lsr_zero", 4, SHF_LSR, 16'h0000, 4'b0101);
    load_reg(6, 16'h8001);
    shf_check("asr", 6, SHF_ASR, 16'hC000, 4'b1001);

    // Two constants on S at once OR together.
    SK0 = 1'b1; SK1 = 1'b1; SMA = 1'b1;
    expect_out("konst_or", OBS_MAR, 32'h00C0);
    tick();

    // MMD wins over SMD; M_bus_out gated by MDM.
    M_bus_in = 16'h1234; MMD = 1'b1; SMD = 1'b1; SK1 = 1'b1;
    tick();
    MDM = 1'b1;
    #1;
    expect_out("mdr_prio", OBS_MBO, 32'h1234);
    drain();
    MDM = 1'b0;
    #1;
    expect_out("mbo_gated", OBS_MBO, 32'h0000);
    drain();
    idle();

    // PSW slot write beats FLG_ALU; PSW slot readable on A.
    load_reg(7, 16'h000A);
    RA[7] = 1'b1; alu_op = ALU_PASS_A; ALS = 1'b1; SR[PSW_IDX] = 1'b1; FLG_ALU = 1'b1;
    expect_out("psw_prio", OBS_PSW, 32'hA);
    tick();
    RA[PSW_IDX] = 1'b1; alu_op = ALU_PASS_A; ALS = 1'b1; SMA = 1'b1;
    expect_out("psw_read", OBS_MAR, 32'h000A);
    tick();

    // Full-scale multiply with an ignored restart at cycle 3.
    mul_run("mul_ffff", 1, 16'hFFFF, 16'hFFFF, 3);

    // Reset during the run aborts the multiply immediately.
    load_reg(2, 16'h1234);
    load_b0(16'h0567);
    RA[2] = 1'b1; B0B = 1'b1; mul_start = 1'b1;
    tick();
    repeat (5) @(posedge CLK);
    #1;
    CLR = 1'b1;
    #1;
    expect_out("abort_busy", OBS_BUSY, 32'd0);
    expect_out("abort_done", OBS_DONE, 32'd0);
    expect_out("abort_psw",  OBS_PSW,  32'd0);
    drain();
    @(negedge CLK);
    CLR = 1'b0;
    @(posedge CLK);
    #1;
    MLH = 1'b1; MLL = 1'b1; SMA = 1'b1;
    expect_out("abort_product", OBS_MAR, 32'd0);
    tick();
    mul_run("mul_after_rst", 2, 16'h0003, 16'h0005, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/datapath_core.md
Name: datapath_core

Overview:
Parametrised successor to the fixed 16-bit datapath. It holds NREG general registers, B0, MDR, MAR, a shifter, an ALU, a self-sequenced shift-add multiplier and an NZVC PSW, all on OR-combined A/B/S buses. The multiplier is internally sequenced with a start/busy/done handshake, so the controller no longer drives multiplier phase strobes. It sits between the microcode controller and the memory interface.

Parameters:
WIDTH, 16, datapath and bus width (>=8)
NREG, 8, number of general registers (2..16)
PSW_IDX, 5, register slot that aliases the PSW (0..NREG-1)
KONST0, 16'h0080, constant driven onto S by SK0
KONST1, 16'h00C0, constant driven onto S by SK1

Ports:
CLK  in  1  clock, all state rising-edge
CLR  in  1  asynchronous active-high reset
M_bus_in  in  WIDTH  memory read data
M_bus_out  out  WIDTH  MDR value when MDM=1, else 0
MAR_out  out  WIDTH  MAR contents
RA  in  NREG  one-hot register-to-A enables
SR  in  NREG  S-to-register load enables
MDA, MMD, SMD, MDM, SMA  in  1 each  MDR->A, M->MDR, S->MDR, MDR->M, S->MAR
SB0, B0B  in  1 each  S->B0 load, B0->B drive
alu_op  in  3  0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 AND, 5 OR, 6 XOR, 7 PASS_A
shf_op  in  3  0 ASL, 1 ASR, 2 LSL, 3 LSR, 4 ROL, 5 ROR, 6 RLC, 7 RRC
ALS, SHS, SK0, SK1  in  1 each  ALU / shifter / KONST0 / KONST1 -> S
mul_start  in  1  start multiply of A bus x B bus
MLH, MLL  in  1 each  product high / low half -> S
mul_busy  out  1  multiplier running
mul_done  out  1  one-cycle pulse when product valid
FLG_ALU, FLG_SFT, FLG_MUL  in  1 each  PSW flag-update strobes
psw  out  4  {N,Z,V,C}

Behaviour:
- Reset: all registers, B0, MDR, MAR, product, PSW = 0. mul_busy=0, mul_done=0, FSM=IDLE. Reset takes effect immediately and aborts any multiply in progress.
- Buses are combinational ORs of gated sources. Multiple enables produce the bitwise OR, with no error. An undriven bus reads 0.
- Register slot PSW_IDX is not a GPR:
  - RA[PSW_IDX] drives {WIDTH-4 zeros, N,Z,V,C} onto A.
  - SR[PSW_IDX] loads psw from S[3:0].
- All register, MDR, MAR and B0 loads occur on the clock edge, so a read of S in the same cycle sees the old value.
- MDR load: if MMD and SMD are both 1, MMD wins.
- ALU:
  - ADC/SBC use the current C.
  - SUB computes A-B. C=1 on borrow.
  - V is signed overflow. For logical ops and PASS_A, V=0 and C=0.
- Shifter:
  - ASR replicates the MSB.
  - RLC/RRC rotate through C.
  - C is the bit shifted out. V = N xor C for ASL, else 0.
- Multiplier FSM, unsigned:
  - IDLE: on mul_start, latch A and B, clear the 2*WIDTH accumulator, go to RUN, mul_busy=1.
  - RUN: one add-shift step per cycle, WIDTH steps, then DONE.
  - DONE: one cycle, mul_done=1, mul_busy=0, back to IDLE.
  - Latency: mul_done is asserted exactly WIDTH+1 cycles after the start edge.
  - mul_start while RUN or DONE is ignored.
  - The product holds until the next accepted start. MLH/MLL read the held product.
- Flag update, priority high to low: SR[PSW_IDX] > FLG_MUL > FLG_ALU > FLG_SFT.
  - ALU/SFT: N = result MSB, Z = result==0, V and C as above.
  - MUL: N = product MSB, Z = product==0, V=0, C = (high half != 0). MUL flags use the held product.
- Widths: all arithmetic is WIDTH bits, with carry taken from bit WIDTH. No X propagation from unselected sources.

Decomposition:
- Package datapath_pkg: alu_op/shf_op encodings, flag bit positions (N=3,Z=2,V=1,C=0), multiplier FSM state enum (IDLE, RUN, DONE).
- One sub-module: seq_multiplier, holding the FSM, accumulator and step counter, with the handshake ports only.

Test Plan:
- Reset mid-RUN: pulse CLR during step 5 -> mul_busy=0, product=0, psw=0 in the same cycle; a new start then runs normally.
- ADD 0x7FFF+0x0001 (R1 on A, B0 on B, ALS, FLG_ALU) -> S=0x8000, psw N=1 Z=0 V=1 C=0.
- SUB 0x0000-0x0001 then SBC 0x0005-0x0002 -> 0xFFFF with C=1; then 0x0002 with C=0.
- RRC of 0x0001 with C=1 (SHS, FLG_SFT) -> 0x8000, C=1, N=1.
- MUL 0xFFFF x 0xFFFF -> mul_done at cycle 17; MLH=0xFFFE, MLL=0x0001; FLG_MUL gives C=1, Z=0. A mul_start at cycle 3 is ignored.
- Simultaneous SR[PSW_IDX] (S=0x000A) and FLG_ALU -> psw=4'b1010; RA[PSW_IDX] then reads 0x000A.
